// File: rtl/signal_sequencer_if.sv
// Signal bundle between the junction phase controller and its surroundings:
// time base, enable, occupancy and green times in; road selection, lamps,
// phase timer and cycle strobe out.
interface signal_sequencer_if #(
  parameter int unsigned TW = 8
) ();

  logic          tick;
  logic          enable;
  logic [3:0]    occ;
  logic [TW-1:0] tg_n;
  logic [TW-1:0] tg_e;
  logic [TW-1:0] tg_s;
  logic [TW-1:0] tg_w;

  logic [1:0]    next_road;
  logic [1:0]    cur_road;
  logic [1:0]    light_n;
  logic [1:0]    light_e;
  logic [1:0]    light_s;
  logic [1:0]    light_w;
  logic [TW-1:0] timer;
  logic          cycle_done;

  // Environment side: drives time base, demand and green times, observes phases.
  modport master (
    output tick, enable, occ, tg_n, tg_e, tg_s, tg_w,
    input  next_road, cur_road, light_n, light_e, light_s, light_w, timer, cycle_done
  );

  // Sequencer side.
  modport slave (
    input  tick, enable, occ, tg_n, tg_e, tg_s, tg_w,
    output next_road, cur_road, light_n, light_e, light_s, light_w, timer, cycle_done
  );

endinterface

// File: rtl/signal_sequencer.sv
// Four-way junction phase controller. Serves roads N->E->S->W in turn, each
// green followed by yellow and all-red, skipping roads with no queued
// vehicles. Every output is a register.
module signal_sequencer #(
  parameter int unsigned TW        = 8,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned MIN_GREEN = 2
) (
  input logic               clk,
  input logic               reset,
  signal_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StGreen,
    StYellow,
    StAllred
  } state_e;

  localparam logic [1:0]    LampRed    = 2'b00;
  localparam logic [1:0]    LampGreen  = 2'b01;
  localparam logic [1:0]    LampYellow = 2'b10;

  localparam logic [TW-1:0] OneW       = TW'(1);
  localparam logic [TW-1:0] YellowW    = TW'(YELLOW_T);
  localparam logic [TW-1:0] AllredW    = TW'(ALLRED_T);
  localparam logic [TW-1:0] MinGreenW  = TW'(MIN_GREEN);

  state_e              state_q, state_d;
  logic [1:0]          cur_q, cur_d;
  logic [1:0]          next_q, next_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                done_q, done_d;
  logic [3:0][1:0]     lamps_q, lamps_d;

  logic [3:0][TW-1:0]  tg_all;
  logic [TW-1:0]       green_load;
  logic [1:0]          sel;

  assign tg_all = {bus.tg_w, bus.tg_s, bus.tg_e, bus.tg_n};

  // Green time for the road about to be served, floored at the minimum green.
  always_comb begin
    green_load = tg_all[next_q];
    if (green_load < MinGreenW) begin
      green_load = MinGreenW;
    end
  end

  // Next road: first occupied road after the current one, wrapping back to
  // the current road last; with no demand at all, simply the following road.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    sel   = cur_q + 2'd1;
    found = 1'b0;
    cand  = cur_q;
    for (int k = 1; k <= 4; k++) begin
      cand = cur_q + 2'(k);
      if (!found && bus.occ[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Phase transitions and timer; an expiring phase is detected at timer<=1 so
  // the timer can never wrap below zero.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    next_d  = next_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          state_d = StGreen;
          cur_d   = next_q;
          timer_d = green_load;
        end
      end
      StGreen: begin
        if (bus.tick) begin
          if (timer_q > OneW) begin
            timer_d = timer_q - OneW;
          end else begin
            state_d = StYellow;
            timer_d = YellowW;
            next_d  = sel;
          end
        end
      end
      StYellow: begin
        if (bus.tick) begin
          if (timer_q > OneW) begin
            timer_d = timer_q - OneW;
          end else begin
            state_d = StAllred;
            timer_d = AllredW;
          end
        end
      end
      StAllred: begin
        if (bus.tick) begin
          if (timer_q > OneW) begin
            timer_d = timer_q - OneW;
          end else begin
            done_d = 1'b1;
            if (bus.enable) begin
              state_d = StGreen;
              cur_d   = next_q;
              timer_d = green_load;
            end else begin
              state_d = StIdle;
              timer_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // Lamp codes follow the next state so they can be registered with it.
  always_comb begin
    lamps_d = {LampRed, LampRed, LampRed, LampRed};
    if (state_d == StGreen) begin
      lamps_d[cur_d] = LampGreen;
    end else if (state_d == StYellow) begin
      lamps_d[cur_d] = LampYellow;
    end
  end

  // State register; reset is a hard stop straight to all-red idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= 2'd0;
      next_q  <= 2'd0;
      timer_q <= '0;
      done_q  <= 1'b0;
      lamps_q <= {LampRed, LampRed, LampRed, LampRed};
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      lamps_q <= lamps_d;
    end
  end

  assign bus.next_road  = next_q;
  assign bus.cur_road   = cur_q;
  assign bus.timer      = timer_q;
  assign bus.cycle_done = done_q;
  assign bus.light_n    = lamps_q[0];
  assign bus.light_e    = lamps_q[1];
  assign bus.light_s    = lamps_q[2];
  assign bus.light_w    = lamps_q[3];

endmodule

// File: tb/tb_signal_sequencer.sv
// Bench for signal_sequencer: a vector table, hand-written corner sequences
// and random stimulus, all checked cycle by cycle against a phase-level model.
module tb_signal_sequencer;

  localparam int unsigned TW = 8;
  localparam int YT = 3;
  localparam int AT = 1;
  localparam int MG = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  signal_sequencer_if #(.TW(TW)) bus ();

  signal_sequencer #(
    .TW       (TW),
    .YELLOW_T (YT),
    .ALLRED_T (AT),
    .MIN_GREEN(MG)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-level model: phase 0 idle, 1 green, 2 yellow, 3 all-red.
  int m_phase = 0;
  int m_road  = 0;
  int m_upnext = 0;
  int m_left  = 0;
  bit m_done  = 1'b0;

  function automatic int green_len(input int t);
    return (t < MG) ? MG : t;
  endfunction

  function automatic int pick_road(input logic [3:0] o, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (o[(from + k) % 4]) return (from + k) % 4;
    end
    return (from + 1) % 4;
  endfunction

  task automatic model_update(input bit r, input bit t, input bit e, input logic [3:0] o,
                              input int tg [4]);
    m_done = 1'b0;
    if (r) begin
      m_phase = 0; m_road = 0; m_upnext = 0; m_left = 0;
    end else if (m_phase == 0) begin
      if (e) begin
        m_phase = 1; m_road = m_upnext; m_left = green_len(tg[m_upnext]);
      end
    end else if (t) begin
      m_left = m_left - 1;
      if (m_left <= 0) begin
        if (m_phase == 1) begin
          m_upnext = pick_road(o, m_road); m_phase = 2; m_left = YT;
        end else if (m_phase == 2) begin
          m_phase = 3; m_left = AT;
        end else begin
          m_done = 1'b1;
          if (e) begin
            m_phase = 1; m_road = m_upnext; m_left = green_len(tg[m_upnext]);
          end else begin
            m_phase = 0; m_left = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [7:0] l;
    l = 8'h00;
    if (m_phase == 1) l[2*m_road +: 2] = 2'b01;
    if (m_phase == 2) l[2*m_road +: 2] = 2'b10;
    return {11'd0, l, 2'(m_road), 2'(m_upnext), 8'(m_left), m_done};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {11'd0, bus.light_w, bus.light_s, bus.light_e, bus.light_n, bus.cur_road,
            bus.next_road, bus.timer, bus.cycle_done};
  endfunction

  function automatic logic [7:0] lamps();
    return {bus.light_w, bus.light_s, bus.light_e, bus.light_n};
  endfunction

  // One clock: inputs are latched for the model, then outputs compared 1 time unit later.
  task automatic step();
    bit r, t, e;
    logic [3:0] o;
    int tg [4];
    r = reset; t = bus.tick; e = bus.enable; o = bus.occ;
    tg[0] = int'(bus.tg_n); tg[1] = int'(bus.tg_e);
    tg[2] = int'(bus.tg_s); tg[3] = int'(bus.tg_w);
    @(posedge clk);
    model_update(r, t, e, o, tg);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic set_tg(input logic [7:0] v);
    bus.tg_n = v; bus.tg_e = v; bus.tg_s = v; bus.tg_w = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         tk;
    bit         en;
    logic [3:0] occ;
    logic [7:0] tg;
    logic [7:0] lights;
    logic [1:0] cur;
    logic [1:0] nxt;
    logic [7:0] tmr;
    bit         done;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit tk, input bit en, input logic [3:0] occ,
                              input logic [7:0] tg, input logic [7:0] lights,
                              input logic [1:0] cur, input logic [1:0] nxt,
                              input logic [7:0] tmr, input bit done);
    vec_t v;
    v.rst = rst; v.tk = tk; v.en = en; v.occ = occ; v.tg = tg; v.lights = lights;
    v.cur = cur; v.nxt = nxt; v.tmr = tmr; v.done = done;
    return v;
  endfunction

  // E green length in cycles for a given initial tg_e and a value written mid-green.
  task automatic run_e_green(input logic [7:0] tge, input logic [7:0] tge_mid, output int cnt);
    cnt = 0;
    set_tg(8'd2); bus.tg_e = tge; bus.occ = 4'hF; bus.tick = 1'b1; bus.enable = 1'b1;
    do_reset();
    for (int i = 0; i < 100 && bus.light_e != 2'b01; i++) step();
    check("e_green_reached", 32'(bus.light_e), 32'd1);
    bus.tg_e = tge_mid;
    for (int i = 0; i < 100 && bus.light_e == 2'b01; i++) begin
      cnt++;
      step();
    end
  endtask

  vec_t vecs[$];

  initial begin
    int g, y, a, viol, cnt;
    logic [7:0] prev_t;
    bit applied_tick;
    bit saw_done;

    reset = 1'b1; bus.tick = 1'b0; bus.enable = 1'b0; bus.occ = 4'hF; set_tg(8'd2);

    // Vector table: tg applies to all roads, lights packed {w,s,e,n}.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'hF, 8'd2, 8'h00, 2'd0, 2'd0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'hF, 8'd2, 8'h01, 2'd0, 2'd0, 8'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd2, 8'h01, 2'd0, 2'd0, 8'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd2, 8'h02, 2'd0, 2'd1, 8'd3, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd2, 8'h02, 2'd0, 2'd1, 8'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd2, 8'h02, 2'd0, 2'd1, 8'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd2, 8'h00, 2'd0, 2'd1, 8'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd2, 8'h04, 2'd1, 2'd1, 8'd2, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'hF, 8'd2, 8'h04, 2'd1, 2'd1, 8'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd2, 8'h04, 2'd1, 2'd1, 8'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h0, 8'd2, 8'h08, 2'd1, 2'd2, 8'd3, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h0, 8'd2, 8'h08, 2'd1, 2'd2, 8'd2, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'hF, 8'd2, 8'h00, 2'd0, 2'd0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 8'd2, 8'h00, 2'd0, 2'd0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 8'd0, 8'h00, 2'd0, 2'd0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'hF, 8'd0, 8'h01, 2'd0, 2'd0, 8'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd1, 8'h01, 2'd0, 2'd0, 8'd1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 8'd1, 8'h02, 2'd0, 2'd1, 8'd3, 1'b0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; bus.tick = vecs[i].tk; bus.enable = vecs[i].en;
      bus.occ = vecs[i].occ; set_tg(vecs[i].tg);
      step();
      check($sformatf("vec%0d", i), dut_vec(),
            {11'd0, vecs[i].lights, vecs[i].cur, vecs[i].nxt, vecs[i].tmr, vecs[i].done});
    end

    // Skip empty roads: only N and S occupied.
    set_tg(8'd2); bus.occ = 4'b0101; bus.tick = 1'b1; bus.enable = 1'b1;
    do_reset();
    for (int i = 0; i < 50 && bus.light_n != 2'b10; i++) step();
    check("skip_next_road", 32'(bus.next_road), 32'd2);
    for (int i = 0; i < 50 && bus.light_n == 2'b10 || lamps() == 8'h00; i++) step();
    check("skip_serves_s", 32'(bus.light_s), 32'd1);

    // No demand anywhere: fall through to the following road.
    bus.occ = 4'b0000;
    do_reset();
    for (int i = 0; i < 50 && bus.light_n != 2'b10; i++) step();
    check("no_occ_next_road", 32'(bus.next_road), 32'd1);

    // Minimum green and mid-green tg changes.
    run_e_green(8'd0, 8'd0, cnt);
    check("min_green_tg0", 32'(cnt), 32'd2);
    run_e_green(8'd1, 8'd1, cnt);
    check("min_green_tg1", 32'(cnt), 32'd2);
    run_e_green(8'd5, 8'd9, cnt);
    check("tg_change_ignored", 32'(cnt), 32'd5);

    // Tick every 4th cycle: E green 20 cycles, yellow 12; timer frozen between ticks.
    set_tg(8'd5); bus.occ = 4'hF; bus.enable = 1'b1; bus.tick = 1'b0;
    do_reset();
    g = 0; y = 0; viol = 0;
    for (int i = 0; i < 400; i++) begin
      bus.tick = (i % 4 == 0);
      applied_tick = bus.tick;
      prev_t = bus.timer;
      step();
      if (i > 0 && !applied_tick && bus.timer != prev_t) viol++;
      if (bus.light_e == 2'b01) g++;
      if (bus.light_e == 2'b10) y++;
      if (bus.light_s == 2'b01) break;
    end
    check("tick_e_green", 32'(g), 32'd20);
    check("tick_e_yellow", 32'(y), 32'd12);
    check("tick_timer_frozen", 32'(viol), 32'd0);

    // Enable drop at timer=3 of N green.
    set_tg(8'd5); bus.occ = 4'hF; bus.tick = 1'b1; bus.enable = 1'b1;
    do_reset();
    for (int i = 0; i < 50 && !(bus.light_n == 2'b01 && bus.timer == 8'd3); i++) step();
    bus.enable = 1'b0;
    g = 0; y = 0; a = 0; saw_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.cycle_done) saw_done = 1'b1;
      if (bus.light_n == 2'b01) g++;
      if (bus.light_n == 2'b10) y++;
      if (lamps() == 8'h00 && bus.timer != 8'd0) a++;
      if (lamps() == 8'h00 && bus.timer == 8'd0) break;
    end
    check("drop_green_rest", 32'(g), 32'd2);
    check("drop_yellow", 32'(y), 32'd3);
    check("drop_allred", 32'(a), 32'd1);
    check("drop_cycle_done", 32'(saw_done), 32'd1);
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (lamps() != 8'h00 || bus.timer != 8'd0) viol++;
    end
    check("idle_all_red", 32'(viol), 32'd0);
    bus.enable = 1'b1;
    step();
    check("restart_e_green", 32'(bus.light_e), 32'd1);

    // Reset at timer=2 of yellow.
    set_tg(8'd3); bus.occ = 4'hF; bus.tick = 1'b1; bus.enable = 1'b1;
    do_reset();
    for (int i = 0; i < 50 && !(bus.light_n == 2'b10 && bus.timer == 8'd2); i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_mid_yellow", dut_vec(), 32'd0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 200 == 0);
      bus.tick = ($urandom % 3 != 0);
      bus.enable = ($urandom % 16 != 0);
      bus.occ = 4'($urandom);
      bus.tg_n = 8'($urandom % 8); bus.tg_e = 8'($urandom % 8);
      bus.tg_s = 8'($urandom % 8); bus.tg_w = 8'($urandom % 8);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
